// File: rtl/stagen_scoreboard_hazard_unit_pkg.sv
// rtl/stagen_scoreboard_hazard_unit_pkg.sv - shared state encoding, widths and counter type for the hazard unit
package stagen_scoreboard_hazard_unit_pkg;

  localparam int DEF_NUM_REGS    = 32;
  localparam int DEF_MAX_PENDING = 3;

  typedef logic [1:0] hu_state_t;
  localparam hu_state_t ST_RUN      = 2'd0;
  localparam hu_state_t ST_DRAIN    = 2'd1;
  localparam hu_state_t ST_FLUSH    = 2'd2;
  localparam hu_state_t ST_REDIRECT = 2'd3;

  function automatic int regsel_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  function automatic int cnt_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

  typedef logic [$clog2(DEF_MAX_PENDING + 1)-1:0] pend_cnt_t;

endpackage

// File: rtl/stagen_scoreboard_hazard_unit_reg_pending_counter.sv
// rtl/stagen_scoreboard_hazard_unit_reg_pending_counter.sv - per-register in-flight write counter
// Net update count + inc - dec; an over-retire clamps at zero and flags underflow.
module stagen_scoreboard_hazard_unit_reg_pending_counter #(
  parameter int MAX_PENDING = 3,
  parameter int CW          = 2,
  parameter int DW          = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic [DW-1:0] dec_i,
  output logic [CW-1:0] count_o,
  output logic          nonzero_o,
  output logic          nonzero_next_o,
  output logic          sat_o,
  output logic          underflow_o
);

  localparam int SW = ((CW > DW) ? CW : DW) + 1;

  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] sum, dec_ext;

  always_comb begin
    sum         = SW'(count_q) + SW'(inc_i);
    dec_ext     = SW'(dec_i);
    underflow_o = (dec_ext > sum);
    count_d     = underflow_o ? '0 : CW'(sum - dec_ext);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o        = count_q;
  assign nonzero_o      = (count_q != '0);
  assign nonzero_next_o = (count_d != '0);
  assign sat_o          = (count_q == CW'(MAX_PENDING));

endmodule

// File: rtl/stagen_scoreboard_hazard_unit.sv
// rtl/stagen_scoreboard_hazard_unit.sv - scoreboard hazard/stall controller with trap sequencing
// Issue gating from per-register pending counts; RUN -> DRAIN -> FLUSH -> REDIRECT on exceptions.
module stagen_scoreboard_hazard_unit
  import stagen_scoreboard_hazard_unit_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int NUM_WB_PORTS = 2,
  parameter int MAX_PENDING  = 3,
  parameter int WB_BYPASS    = 1,
  parameter int RW           = $clog2(NUM_REGS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  input  logic [RW-1:0]              issue_rs1_i,
  input  logic [RW-1:0]              issue_rs2_i,
  input  logic                       issue_use_rs1_i,
  input  logic                       issue_use_rs2_i,
  input  logic [RW-1:0]              issue_rd_i,
  input  logic                       issue_wen_i,
  output logic                       issue_fire_o,
  output logic                       issue_stall_o,
  input  logic [NUM_WB_PORTS-1:0]    wb_valid_i,
  input  logic [NUM_WB_PORTS*RW-1:0] wb_rd_i,
  input  logic                       mispredict_i,
  input  logic                       exception_i,
  input  logic [31:0]                trap_vector_i,
  output logic                       pc_en_o,
  output logic                       flush_front_o,
  output logic                       flush_all_o,
  output logic                       insert_priv_pc_o,
  output logic [31:0]                priv_pc_o,
  output logic [NUM_REGS-1:0]        busy_regs_o,
  output logic                       wb_underflow_o
);

  localparam int CW = cnt_width(MAX_PENDING);
  localparam int DW = $clog2(NUM_WB_PORTS + 1);
  localparam int SW = ((CW > DW) ? CW : DW) + 1;

  logic [DW-1:0]       dec [NUM_REGS];
  logic [CW-1:0]       pend [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec, nz_vec, nz_next_vec, nz_after_wb_vec, eff_nz_vec, sat_vec, uf_vec;
  logic                raw1, raw2, sat_hit, hazard, run;
  hu_state_t           state_q, state_d;
  logic [31:0]         priv_pc_q, priv_pc_d;

  // Per-register retire count; x0 is never tracked so it never decrements or underflows.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      dec[r] = '0;
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (r != 0 && wb_valid_i[p] && wb_rd_i[p*RW +: RW] == RW'(r)) dec[r] = dec[r] + DW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    assign inc_vec[g]         = (g != 0) && issue_fire_o && issue_wen_i && (issue_rd_i == RW'(g));
    assign nz_after_wb_vec[g] = (SW'(pend[g]) > SW'(dec[g]));

    stagen_scoreboard_hazard_unit_reg_pending_counter #(
      .MAX_PENDING(MAX_PENDING),
      .CW         (CW),
      .DW         (DW)
    ) u_cnt (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .inc_i         (inc_vec[g]),
      .dec_i         (dec[g]),
      .count_o       (pend[g]),
      .nonzero_o     (nz_vec[g]),
      .nonzero_next_o(nz_next_vec[g]),
      .sat_o         (sat_vec[g]),
      .underflow_o   (uf_vec[g])
    );
  end

  // Bypass lets a same-cycle writeback retire the last pending write before the read.
  assign eff_nz_vec = (WB_BYPASS != 0) ? nz_after_wb_vec : nz_vec;

  assign run     = (state_q == ST_RUN);
  assign raw1    = issue_use_rs1_i && (issue_rs1_i != '0) && eff_nz_vec[issue_rs1_i];
  assign raw2    = issue_use_rs2_i && (issue_rs2_i != '0) && eff_nz_vec[issue_rs2_i];
  assign sat_hit = issue_wen_i && (issue_rd_i != '0) && sat_vec[issue_rd_i];
  assign hazard  = raw1 | raw2 | sat_hit;

  assign issue_fire_o   = issue_valid_i && !hazard && run && !exception_i;
  assign issue_stall_o  = issue_valid_i && !issue_fire_o;
  assign busy_regs_o    = nz_vec;
  assign wb_underflow_o = |uf_vec;
  assign priv_pc_o      = priv_pc_q;

  always_comb begin
    state_d          = state_q;
    priv_pc_d        = priv_pc_q;
    pc_en_o          = 1'b0;
    flush_front_o    = 1'b0;
    flush_all_o      = 1'b0;
    insert_priv_pc_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        pc_en_o = !(issue_valid_i && hazard);
        if (exception_i) begin
          state_d   = ST_DRAIN;
          priv_pc_d = trap_vector_i;
        end else if (mispredict_i) begin
          flush_front_o = 1'b1;
          pc_en_o       = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (nz_next_vec == '0) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_all_o = 1'b1;
        state_d     = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        insert_priv_pc_o = 1'b1;
        pc_en_o          = 1'b1;
        state_d          = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      priv_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      priv_pc_q <= priv_pc_d;
    end
  end

endmodule
